// File: rtl/vga_scan_out_if.sv
// Upstream compositor link for vga_scan_out.
// Scan-out publishes coordinate and tick, compositor returns colour.
interface vga_scan_out_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_en;
    logic [7:0] pix_color;

    modport master (
        output pix_x,
        output pix_y,
        output pix_en,
        input  pix_color
    );

    modport slave (
        input  pix_x,
        input  pix_y,
        input  pix_en,
        output pix_color
    );
endinterface

// File: rtl/vga_scan_out.sv
// FDPaint VGA scan-out: 640x480@60 timing, pixel tick, registered pins.
// Pins lag the published coordinate by exactly one pixel tick.
module vga_scan_out #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_scan_out_if.master pix,
    output logic [2:0]     vgaRed,
    output logic [2:0]     vgaGreen,
    output logic [2:1]     vgaBlue,
    output logic           Hsync,
    output logic           Vsync,
    output logic           video_on,
    output logic           frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
    localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          von_q, von_d;
    logic          fs_q, fs_d;
    logic          tick;
    logic          active;

    assign tick       = (div_q == DIV_MAX);
    assign pix.pix_en = tick;
    assign pix.pix_x  = h_q;
    assign pix.pix_y  = v_q;

    assign active = (h_q < H_VIS) && (v_q < V_VIS);

    assign vgaRed      = rgb_q[7:5];
    assign vgaGreen    = rgb_q[4:2];
    assign vgaBlue     = rgb_q[1:0];
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign video_on    = von_q;
    assign frame_start = fs_q;

    // Clock divider producing the one-clk pixel tick.
    always_comb begin
        div_d = div_q;
        if (div_q == DIV_MAX) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // Raster counters and frame-origin detect, advanced on the tick.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fs_d = 1'b0;
        if (tick) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                if (v_q == V_MAX) begin
                    v_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Pin stage: colour, syncs and active flag from pre-advance h/v.
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        von_d   = von_q;
        if (tick) begin
            rgb_d   = active ? pix.pix_color : 8'h00;
            hsync_d = ~((h_q >= HS_LO) && (h_q <= HS_HI));
            vsync_d = ~((v_q >= VS_LO) && (v_q <= VS_HI));
            von_d   = active;
        end
    end

    // State registers; syncs idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            von_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            von_q   <= von_d;
            fs_q    <= fs_d;
        end
    end
endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Final display stage of FDPaint; drives the VGA connector pins.
- Generates 640x480@60 Hz timing from the 50 MHz board clock using a divided pixel enable.
- Publishes the current scan coordinate to the upstream canvas/cursor compositor and accepts its 8-bit RRRGGGBB pixel colour.
- Registers colour and sync onto vgaRed/vgaGreen/vgaBlue/Hsync/Vsync with blanking enforced.

Parameters:
CLK_DIV, 2, clk cycles per pixel tick (50 MHz / 2 = 25 MHz)
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous, active-low reset
pix_color  in  8  upstream colour for (pix_x,pix_y): [7:5] R, [4:2] G, [1:0] B
pix_x  out  10  current horizontal counter, 0..H_TOTAL-1
pix_y  out  10  current vertical counter, 0..V_TOTAL-1
pix_en  out  1  one-clk pixel tick strobe
vgaRed  out  3  red pins
vgaGreen  out  3  green pins
vgaBlue  out  2  blue pins, indexed [2:1]
Hsync  out  1  horizontal sync, active low
Vsync  out  1  vertical sync, active low
video_on  out  1  registered active-area flag, aligned with colour pins
frame_start  out  1  one-clk pulse at frame origin

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All state is cleared asynchronously on rst_n low. Release is used synchronously.
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = 1 exactly when div == CLK_DIV-1, so it is high 1 of every CLK_DIV clk cycles.
- With CLK_DIV=1, pix_en is held constantly high.
- Counters update only on pix_en:
  - h increments, wrapping to 0 after H_TOTAL-1.
  - When h wraps, v increments, wrapping to 0 after V_TOTAL-1.
- pix_x = h and pix_y = v, driven combinationally from the counter registers.
- Upstream contract: pix_color must be stable and valid for (pix_x,pix_y) by the clk edge on which pix_en is high. That gives upstream CLK_DIV clk cycles of budget.
- Output register stage, loaded on pix_en from the pre-advance counter values (h,v) and pix_color:
  - active = (h < H_VISIBLE) && (v < V_VISIBLE).
  - {vgaRed,vgaGreen,vgaBlue} = active ? pix_color : 8'h00.
  - Hsync = ~(h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]), i.e. [656,751].
  - Vsync = ~(v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]), i.e. [490,491].
  - video_on = active.
- Latency: the pins reflect coordinate (x,y) from the pix_en edge that consumes it until the next pix_en, which is exactly one pixel tick behind the counters. Sync, colour and video_on are therefore mutually aligned.
- frame_start: registered. High for exactly one clk in the cycle after the pix_en on which (h,v) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0). Low otherwise.
- Reset values: div=0, h=0, v=0, pix_x=0, pix_y=0, pix_en=0 (only 1 if CLK_DIV=1), colour pins 0, Hsync=1, Vsync=1, video_on=0, frame_start=0.
- Reset mid-frame: pins go immediately to reset values. The first pix_en after release arrives CLK_DIV-1 cycles later and processes (0,0). There is no partial sync pulse beyond the reset assertion.
- pix_color is ignored outside the active area and between ticks. No combinational path exists from pix_color to any pin.

Test Plan:
1. Reset: assert rst_n=0 mid-line (h≈700) -> Hsync=1, Vsync=1, colour pins 0 and pix_x=0 asynchronously. After release, first pix_en on clk 2 and pix_x→1 after it.
2. Line timing (CLK_DIV=2) -> Hsync falls 1314 clk after reset release (tick 656 registered). Low for exactly 192 clk. Period 1600 clk.
3. Frame timing -> Vsync low for exactly 2 lines (3200 clk). Fall-to-fall spacing 840000 clk. frame_start pulses once per 840000 clk, one clk wide, in the cycle after the wrap tick.
4. Colour pass-through: hold pix_color=8'hE3 -> pins R=7, G=0, B=3 while video_on=1. Pins are 0 throughout h≥640 or v≥480 despite the nonzero input.
5. Latency: drive pix_color = pix_x[7:0] -> on each pix_en the pins equal pix_x-1 (mod line). video_on rises together with the first visible colour.
6. Boundary: at h=639→640 and v=479→480, colour blanks exactly one tick after the counter crosses. No glitch on Hsync/Vsync at the counter wraps (799→0, 524→0).
